// File: rtl/panda_risc_v_clint_tmr.sv
// Machine timer (mtime/mtimecmp) and software interrupt (msip) behind an ICB slave port.
// Optional feature macro: PANDA_CLINT_MTIME_SNAP_EN -- a read of mtime[31:0] latches
// mtime[63:32] into a shadow that the following mtime[63:32] read returns.
module panda_risc_v_clint_tmr #(
   parameter int unsigned CLK_DIV          = 1,
   parameter int unsigned simulation_delay = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] s_icb_cmd_addr,
   input  logic        s_icb_cmd_read,
   input  logic [31:0] s_icb_cmd_wdata,
   input  logic [3:0]  s_icb_cmd_wmask,
   input  logic        s_icb_cmd_valid,
   output logic        s_icb_cmd_ready,
   output logic [31:0] s_icb_rsp_rdata,
   output logic        s_icb_rsp_err,
   output logic        s_icb_rsp_valid,
   input  logic        s_icb_rsp_ready,
   output logic        tmr_itr_req,
   output logic        sw_itr_req
);

   // Register updates are zero-delay in RTL; simulation_delay is only range-checked here.
   if (CLK_DIV == 0 || CLK_DIV > 65535 || simulation_delay > 1000) begin : g_bad_param
      $error("panda_risc_v_clint_tmr: illegal CLK_DIV or simulation_delay");
   end

   localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

   typedef enum logic {StIdle, StRsp} bus_st_e;

   bus_st_e     st_q, st_d;
   logic [15:0] presc_q, presc_d;
   logic        tick;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic        tmr_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        cmd_fire;
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  sel;
   logic [31:0] rd_data;
   logic        rd_err;
   logic [31:0] mtime_hi_rd;
   logic        unused_addr;

   assign sel         = s_icb_cmd_addr[4:2];
   assign unused_addr = ^{s_icb_cmd_addr[31:5], s_icb_cmd_addr[1:0]};
   assign wr_en       = cmd_fire & ~s_icb_cmd_read;
   assign rd_en       = cmd_fire & s_icb_cmd_read;
   assign tick        = (presc_q == DivLast);

   // Byte-masked merge of write data into an existing word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

`ifdef PANDA_CLINT_MTIME_SNAP_EN
   logic [31:0] mtime_hi_snap_q;

   // Capture the upper word together with each lower-word read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mtime_hi_snap_q <= '0;
      end else if (rd_en && (sel == 3'd0)) begin
         mtime_hi_snap_q <= mtime_q[63:32];
      end
   end

   assign mtime_hi_rd = mtime_hi_snap_q;
`else
   assign mtime_hi_rd = mtime_q[63:32];
`endif

   // Bus FSM next state: accept in idle, hold the response until rsp_ready.
   always_comb begin
      st_d     = st_q;
      cmd_fire = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (s_icb_cmd_valid) begin
               cmd_fire = 1'b1;
               st_d     = StRsp;
            end
         end
         StRsp: begin
            if (s_icb_rsp_ready) st_d = StIdle;
         end
         default: st_d = StIdle;
      endcase
   end

   // Read mux over the pre-write register values.
   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (sel)
         3'd0:    rd_data = mtime_q[31:0];
         3'd1:    rd_data = mtime_hi_rd;
         3'd2:    rd_data = mtimecmp_q[31:0];
         3'd3:    rd_data = mtimecmp_q[63:32];
         3'd4:    rd_data = {31'd0, msip_q};
         default: rd_err  = 1'b1;
      endcase
   end

   // Timer next state: increment first, then written bytes override it.
   always_comb begin
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d    = mtime_q + 64'(tick);
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr_en) begin
         case (sel)
            3'd0: mtime_d[31:0]     = merge_bytes(mtime_d[31:0], s_icb_cmd_wdata,
                                                  s_icb_cmd_wmask);
            3'd1: mtime_d[63:32]    = merge_bytes(mtime_d[63:32], s_icb_cmd_wdata,
                                                  s_icb_cmd_wmask);
            3'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], s_icb_cmd_wdata,
                                                  s_icb_cmd_wmask);
            3'd3: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], s_icb_cmd_wdata,
                                                  s_icb_cmd_wmask);
            3'd4: begin
               if (s_icb_cmd_wmask[0]) msip_d = s_icb_cmd_wdata[0];
            end
            default: ;
         endcase
      end
   end

   // State registers for the timer, interrupts and bus response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q       <= StIdle;
         presc_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         tmr_q      <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         tmr_q      <= (mtime_q >= mtimecmp_q);
         if (cmd_fire) begin
            rdata_q <= s_icb_cmd_read ? rd_data : 32'd0;
            err_q   <= rd_err;
         end
      end
   end

   assign s_icb_cmd_ready = (st_q == StIdle);
   assign s_icb_rsp_valid = (st_q == StRsp);
   assign s_icb_rsp_rdata = rdata_q;
   assign s_icb_rsp_err   = err_q;
   assign tmr_itr_req     = tmr_q;
   assign sw_itr_req      = msip_q;

endmodule

// File: tb/tb_panda_risc_v_clint_tmr.sv
// Directed bench for panda_risc_v_clint_tmr: one instance with CLK_DIV=4, a second with
// CLK_DIV=1 sharing the same bus stimulus for the single-cycle carry case.
module tb_panda_risc_v_clint_tmr;
   localparam int unsigned Div = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] addr, wdata;
   logic        rd;
   logic [3:0]  wmask;
   logic        cmd_valid, rsp_ready;

   logic        cmd_ready, rsp_err, rsp_valid, tmr, sw;
   logic [31:0] rdata;
   logic        cmd_ready_1, rsp_err_1, rsp_valid_1, tmr_1, sw_1;
   logic [31:0] rdata_1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pcnt     = 0;

   typedef struct {
      string       tag;
      logic        chk_rd;
      logic [31:0] rdata;
      logic        err;
      logic        chk1;
      logic [31:0] rdata1;
   } exp_t;
   exp_t sb[$];

`ifdef PANDA_CLINT_MTIME_SNAP_EN
   localparam logic [31:0] SnapHi = 32'd0;
`else
   localparam logic [31:0] SnapHi = 32'd1;
`endif

   panda_risc_v_clint_tmr #(.CLK_DIV(Div), .simulation_delay(1)) u_dut (
      .clk(clk), .resetn(resetn),
      .s_icb_cmd_addr(addr), .s_icb_cmd_read(rd), .s_icb_cmd_wdata(wdata),
      .s_icb_cmd_wmask(wmask), .s_icb_cmd_valid(cmd_valid), .s_icb_cmd_ready(cmd_ready),
      .s_icb_rsp_rdata(rdata), .s_icb_rsp_err(rsp_err), .s_icb_rsp_valid(rsp_valid),
      .s_icb_rsp_ready(rsp_ready), .tmr_itr_req(tmr), .sw_itr_req(sw)
   );

   panda_risc_v_clint_tmr #(.CLK_DIV(1), .simulation_delay(1)) u_dut1 (
      .clk(clk), .resetn(resetn),
      .s_icb_cmd_addr(addr), .s_icb_cmd_read(rd), .s_icb_cmd_wdata(wdata),
      .s_icb_cmd_wmask(wmask), .s_icb_cmd_valid(cmd_valid), .s_icb_cmd_ready(cmd_ready_1),
      .s_icb_rsp_rdata(rdata_1), .s_icb_rsp_err(rsp_err_1), .s_icb_rsp_valid(rsp_valid_1),
      .s_icb_rsp_ready(rsp_ready), .tmr_itr_req(tmr_1), .sw_itr_req(sw_1)
   );

   always #5 clk = ~clk;

   // Cycle index and the expected prescaler phase of the current cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!resetn) pcnt <= 0;
      else         pcnt <= (pcnt == int'(Div) - 1) ? 0 : pcnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Drive one command at the current negedge; returns at the negedge after acceptance.
   task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic chk1, input logic [31:0] exp1,
                        input string tag);
      exp_t e;
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      rd = r; addr = a; wdata = d; wmask = m; cmd_valid = 1'b1;
      e.tag = tag; e.chk_rd = chk_rd; e.rdata = exp_rd; e.err = exp_err;
      e.chk1 = chk1; e.rdata1 = exp1;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err,
                         input string tag);
      issue(1'b1, a, 32'd0, 4'h0, 1'b1, exp_rd, exp_err, 1'b0, 32'd0, tag);
      step(1);
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic exp_err, input string tag);
      issue(1'b0, a, d, m, 1'b0, 32'd0, exp_err, 1'b0, 32'd0, tag);
      step(1);
   endtask

   // Response side of the scoreboard: pop on every completed handshake.
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (resetn && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            if (e.chk_rd) check({e.tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
            check({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
            if (e.chk1) check({e.tag, "_rdata_div1"}, 64'(rdata_1), 64'(e.rdata1));
         end
      end
   end

   initial begin
      int t_mw;
      int rise;
      resetn = 1'b0; rd = 1'b1; addr = '0; wdata = '0; wmask = '0;
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_err", 64'(rsp_err), 64'd0);
      check("rst_tmr", 64'(tmr), 64'd0);
      check("rst_sw", 64'(sw), 64'd0);
      resetn = 1'b1;

      // Reset values; mtime is still 0 before the first tick completes.
      rd_reg(32'h00, 32'h0000_0000, 1'b0, "rst_mtime_lo");
      rd_reg(32'h04, 32'h0000_0000, 1'b0, "rst_mtime_hi");
      rd_reg(32'h08, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
      rd_reg(32'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
      rd_reg(32'h10, 32'h0000_0000, 1'b0, "rst_msip");

      // Unmapped addresses.
      rd_reg(32'h14, 32'h0000_0000, 1'b1, "unmap_rd14");
      wr_reg(32'h1C, 32'h0000_DEAD, 4'hF, 1'b1, "unmap_wr1c");
      rd_reg(32'h18, 32'h0000_0000, 1'b1, "unmap_rd18");
      rd_reg(32'h08, 32'hFFFF_FFFF, 1'b0, "post_unmap_cmp_lo");
      rd_reg(32'h0C, 32'hFFFF_FFFF, 1'b0, "post_unmap_cmp_hi");
      rd_reg(32'h10, 32'h0000_0000, 1'b0, "post_unmap_msip");

      // Timer: cmp = {0,10}; mtime = 0 written in a tick cycle.
      wr_reg(32'h08, 32'd10, 4'hF, 1'b0, "cmp_lo_10");
      wr_reg(32'h04, 32'd0, 4'hF, 1'b0, "mtime_hi_0");
      while (pcnt != int'(Div) - 1) @(negedge clk);
      t_mw = cyc;
      wr_reg(32'h00, 32'd0, 4'hF, 1'b0, "mtime_lo_0");
      wr_reg(32'h0C, 32'd0, 4'hF, 1'b0, "cmp_hi_0");
      check("tmr_low_before", 64'(tmr), 64'd0);
      rise = -1;
      while (cyc < t_mw + 100 && rise < 0) begin
         if (tmr) rise = cyc;
         else @(negedge clk);
      end
      check("tmr_rise_delay", 64'(rise - (t_mw + 1)), 64'd41);

      // Raising cmp_hi clears the condition; request drops two cycles after acceptance.
      issue(1'b0, 32'h0C, 32'd1, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "cmp_hi_1");
      check("tmr_fall_n1", 64'(tmr), 64'd1);
      step(1);
      check("tmr_fall_n2", 64'(tmr), 64'd0);

      // Carry: lo = FFFF_FFFF written so that a tick lands one cycle after it is visible.
      wr_reg(32'h04, 32'd0, 4'hF, 1'b0, "carry_hi_0");
      while (pcnt != 1) @(negedge clk);
      wr_reg(32'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, "carry_lo_ff");
      issue(1'b1, 32'h00, 32'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, "carry_rd_lo");
      step(1);
      issue(1'b1, 32'h04, 32'd0, 4'h0, 1'b1, SnapHi, 1'b0, 1'b1, 32'd1, "carry_rd_hi");
      step(1);
      rd_reg(32'h00, 32'd0, 1'b0, "carry_rd_lo2");
      rd_reg(32'h04, 32'd1, 1'b0, "carry_rd_hi2");

      // Software interrupt.
      check("sw_before", 64'(sw), 64'd0);
      issue(1'b0, 32'h10, 32'd1, 4'b0001, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "msip_set");
      check("sw_set", 64'(sw), 64'd1);
      check("sw_set_div1", 64'(sw_1), 64'd1);
      step(1);
      issue(1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "msip_nomask");
      check("sw_nomask_n1", 64'(sw), 64'd1);
      step(1);
      check("sw_nomask_n2", 64'(sw), 64'd1);
      rd_reg(32'h10, 32'd1, 1'b0, "msip_rd1");
      wr_reg(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, "msip_all_ones");
      rd_reg(32'h10, 32'd1, 1'b0, "msip_rd_upper_zero");
      issue(1'b0, 32'h10, 32'd0, 4'b0001, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, "msip_clr");
      check("sw_clr", 64'(sw), 64'd0);
      step(1);

      // Response back-pressure: rsp held stable, no new command accepted.
      rsp_ready = 1'b0;
      issue(1'b1, 32'h08, 32'd0, 4'h0, 1'b1, 32'd10, 1'b0, 1'b0, 32'd0, "stall_rd");
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_rdata", 64'(rdata), 64'd10);
         check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
         step(1);
      end
      rsp_ready = 1'b1;
      step(1);
      check("stall_release_ready", 64'(cmd_ready), 64'd1);

      // Reset mid-transaction drops the pending response.
      rsp_ready = 1'b0;
      issue(1'b1, 32'h10, 32'd0, 4'h0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, "abort_rd");
      resetn = 1'b0;
      #1;
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      step(1);
      resetn    = 1'b1;
      rsp_ready = 1'b1;
      rd_reg(32'h08, 32'hFFFF_FFFF, 1'b0, "abort_cmp_lo");
      check("abort_tmr", 64'(tmr), 64'd0);

      step(3);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
